// File: rtl/fft_peak_pkg.sv
// Shared definitions for the FFT spectral-peak detector: default sizing,
// the (power, idx) candidate type and the magnitude helpers.
package fft_peak_pkg;

  localparam int DW_DEF      = 16;
  localparam int NBINS_DEF   = 16;
  localparam int LANES_DEF   = 4;
  localparam int NFRAMES_DEF = 64;

  localparam int IDXW  = $clog2(NBINS_DEF);
  localparam int PW    = 2*DW_DEF + 1;
  localparam int BEATS = NBINS_DEF / LANES_DEF;

  typedef struct packed {
    logic [PW-1:0]   power;
    logic [IDXW-1:0] idx;
  } cand_t;

  // Exact magnitude: the most-negative value maps to its positive twin.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] x);
    return x[31] ? 32'(-x) : 32'(x);
  endfunction

  function automatic logic [64:0] mag_sq(input logic [31:0] re, input logic [31:0] im);
    logic [64:0] a;
    logic [64:0] b;
    a = {33'd0, re};
    b = {33'd0, im};
    return a*a + b*b;
  endfunction

endpackage

// File: rtl/fft_peak_max_tree.sv
// Combinational LANES-input argmax; balanced heap-ordered tree, left
// (lower-lane) operand wins ties.
module fft_peak_max_tree #(
  parameter int LANES = 4,
  parameter int PW    = 33,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*PW-1:0] powers,
  output logic [PW-1:0]       max_power,
  output logic [LW-1:0]       max_lane
);

  logic [PW-1:0] np [1:2*LANES-1];
  logic [LW-1:0] ni [1:2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign np[LANES+i] = powers[PW*i +: PW];
    assign ni[LANES+i] = LW'(i);
  end

  for (genvar n = 1; n < LANES; n++) begin : g_node
    assign np[n] = (np[2*n] >= np[2*n+1]) ? np[2*n] : np[2*n+1];
    assign ni[n] = (np[2*n] >= np[2*n+1]) ? ni[2*n] : ni[2*n+1];
  end

  assign max_power = np[1];
  assign max_lane  = ni[1];

endmodule

// File: rtl/fft_peak_detector.sv
// Streaming |X|^2 peak detector: S1 power, S2 beat argmax, S3 frame
// accumulator, then registered result. Optional threshold: FFT_PEAK_THRESH_EN.
module fft_peak_detector
  import fft_peak_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NBINS   = NBINS_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int NFRAMES = NFRAMES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [LANES*2*DW-1:0]    in_data,
  output logic                     out_valid,
  output logic [$clog2(NBINS)-1:0] out_idx,
  output logic [2*DW:0]            out_power,
  output logic [15:0]              frame_cnt,
  output logic                     done
`ifdef FFT_PEAK_THRESH_EN
  ,
  input  logic [2*DW:0]            thresh,
  output logic                     out_nopeak
`endif
);

  localparam int IW  = $clog2(NBINS);
  localparam int P_W = 2*DW + 1;
  localparam int NB  = NBINS / LANES;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [BW-1:0]        bcnt;
  logic [LANES*P_W-1:0] pow_d;

  logic                 s1_v, s1_first, s1_last;
  logic [BW-1:0]        s1_beat;
  logic [LANES*P_W-1:0] s1_pow;

  logic [P_W-1:0]       tree_pow;
  logic [LW-1:0]        tree_lane;

  logic                 s2_v, s2_first, s2_last;
  logic [P_W-1:0]       s2_pow;
  logic [IW-1:0]        s2_idx;

  logic                 s3_v;
  logic [P_W-1:0]       acc_pow;
  logic [IW-1:0]        acc_idx;

  always_comb begin
    pow_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pow_d[P_W*i +: P_W] = P_W'(mag_sq(
        abs_mag(32'(signed'(in_data[2*DW*i+DW +: DW]))),
        abs_mag(32'(signed'(in_data[2*DW*i +: DW])))));
    end
  end

  fft_peak_max_tree #(.LANES(LANES), .PW(P_W), .LW(LW)) u_tree (
    .powers    (s1_pow),
    .max_power (tree_pow),
    .max_lane  (tree_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt      <= '0;
      s1_v      <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_beat   <= '0;
      s1_pow    <= '0;
      s2_v      <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_pow    <= '0;
      s2_idx    <= '0;
      s3_v      <= 1'b0;
      acc_pow   <= '0;
      acc_idx   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_power <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
`ifdef FFT_PEAK_THRESH_EN
      out_nopeak <= 1'b0;
`endif
    end else begin
      if (clr)
        bcnt <= '0;
      else if (in_valid)
        bcnt <= (bcnt == BW'(NB-1)) ? '0 : bcnt + 1'b1;

      s1_v     <= in_valid && !clr;
      s1_first <= (bcnt == '0);
      s1_last  <= (bcnt == BW'(NB-1));
      s1_beat  <= bcnt;
      s1_pow   <= pow_d;

      s2_v     <= s1_v && !clr;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_pow   <= tree_pow;
      s2_idx   <= IW'(int'(s1_beat) * LANES + int'(tree_lane));

      // s3_v flags that acc now holds a complete frame, last beat included.
      s3_v <= s2_v && s2_last && !clr;
      if (s2_v && (s2_first || s2_pow > acc_pow)) begin
        acc_pow <= s2_pow;
        acc_idx <= s2_idx;
      end

      out_valid <= s3_v && !clr;
      if (s3_v && !clr) begin
        out_power <= acc_pow;
`ifdef FFT_PEAK_THRESH_EN
        out_nopeak <= (acc_pow < thresh);
        out_idx    <= (acc_pow < thresh) ? '0 : acc_idx;
`else
        out_idx    <= acc_idx;
`endif
        frame_cnt <= frame_cnt + 16'd1;
        if (frame_cnt == 16'(NFRAMES-1))
          done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Self-checking bench for fft_peak_detector: directed frames plus random
// back-to-back frames scored against a per-frame argmax model.
module tb_fft_peak_detector;

  localparam int DW    = 16;
  localparam int NBINS = 16;
  localparam int LANES = 4;
  localparam int BEATS = NBINS / LANES;
  localparam int NF    = 64;

  logic                  clk = 1'b0;
  logic                  rst, clr, in_valid;
  logic [LANES*2*DW-1:0] in_data;
  logic                  out_valid;
  logic [3:0]            out_idx;
  logic [2*DW:0]         out_power;
  logic [15:0]           frame_cnt;
  logic                  done;
`ifdef FFT_PEAK_THRESH_EN
  logic [2*DW:0]         thresh;
  logic                  out_nopeak;
`endif

  fft_peak_detector #(.DW(DW), .NBINS(NBINS), .LANES(LANES), .NFRAMES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_power (out_power),
    .frame_cnt (frame_cnt),
    .done      (done)
`ifdef FFT_PEAK_THRESH_EN
    ,
    .thresh    (thresh),
    .out_nopeak(out_nopeak)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int     idx;
    longint pw;
    bit     nopeak;
  } exp_t;

  exp_t exp_q[$];
  int   re_a [NBINS];
  int   im_a [NBINS];
  int   tests = 0, fails = 0;
  int   cyc = 0, nvalid = 0, vcyc = 0, exp_fc = 0, last_c = 0;
  longint th_model = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: first bin (lowest index) holding the largest re^2+im^2.
  function automatic void model(output int idx, output longint pw);
    longint p;
    idx = 0;
    pw  = -1;
    for (int b = 0; b < NBINS; b++) begin
      p = longint'(re_a[b]) * re_a[b] + longint'(im_a[b]) * im_a[b];
      if (p > pw) begin
        pw  = p;
        idx = b;
      end
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (out_valid) begin
      nvalid++;
      vcyc = cyc;
      exp_fc++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(nvalid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_idx", 64'(out_idx), 64'(e.idx));
        chk("out_power", 64'(out_power), 64'(e.pw));
`ifdef FFT_PEAK_THRESH_EN
        chk("out_nopeak", 64'(out_nopeak), 64'(e.nopeak));
`endif
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
        chk("done", 64'(done), 64'(exp_fc >= NF));
      end
    end
    cyc++;
  end

  task automatic drive_beat(input int b, input bit with_clr);
    @(negedge clk);
    in_valid = 1'b1;
    clr      = with_clr;
    for (int i = 0; i < LANES; i++)
      in_data[2*DW*i +: 2*DW] = {re_a[b*LANES+i][DW-1:0], im_a[b*LANES+i][DW-1:0]};
    last_c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr      = 1'b0;
    end
  endtask

  task automatic send_frame(input int gap);
    exp_t e;
    int   idx;
    longint pw;
    model(idx, pw);
    e.nopeak = (pw < th_model);
    e.idx    = e.nopeak ? 0 : idx;
    e.pw     = pw;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(b, 1'b0);
      if (b < BEATS-1) idle(gap);
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_result(input int n);
    int k = 0;
    while (nvalid < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("result_arrived", 64'(nvalid), 64'(n));
  endtask

  task automatic fill(input int re, input int im);
    for (int b = 0; b < NBINS; b++) begin
      re_a[b] = re;
      im_a[b] = im;
    end
  endtask

  task automatic fill_rand(input int span);
    for (int b = 0; b < NBINS; b++) begin
      re_a[b] = int'($urandom_range(2*span)) - span;
      im_a[b] = int'($urandom_range(2*span)) - span;
    end
  endtask

  initial begin
    int p, q;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef FFT_PEAK_THRESH_EN
    thresh = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_idx", 64'(out_idx), 64'(0));
    chk("rst_out_power", 64'(out_power), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    idle(2);

    fill(10, 10);
    re_a[9] = 300; im_a[9] = -400;
    send_frame(0);
    idle(1);
    wait_result(1);
    chk("f1_latency", 64'(vcyc), 64'(last_c + 4));
    chk("f1_idx", 64'(out_idx), 64'(9));
    chk("f1_power", 64'(out_power), 64'(250000));
    chk("f1_frame_cnt", 64'(frame_cnt), 64'(1));

    fill(0, 0);
    re_a[3] = -32768; re_a[12] = -32768;
    send_frame(0);
    idle(1);
    wait_result(2);
    chk("tie_idx", 64'(out_idx), 64'(3));
    chk("tie_power", 64'(out_power), 64'(1073741824));

    fill(0, 0);
    re_a[15] = 1; im_a[15] = 1;
    send_frame(2);
    idle(2);
    wait_result(3);
    idle(6);
    chk("gap_count", 64'(nvalid), 64'(3));
    chk("gap_idx", 64'(out_idx), 64'(15));
    chk("gap_power", 64'(out_power), 64'(2));

    fill_rand(100);
    drive_beat(0, 1'b0);
    drive_beat(1, 1'b0);
    drive_beat(2, 1'b0);
    drive_beat(3, 1'b1);
    idle(8);
    chk("clr_no_result", 64'(nvalid), 64'(3));
    chk("clr_hold_idx", 64'(out_idx), 64'(15));
    chk("clr_hold_cnt", 64'(frame_cnt), 64'(3));
    fill_rand(100);
    re_a[0] = 1000; im_a[0] = -1000;
    send_frame(0);
    idle(1);
    wait_result(4);
    idle(4);
    chk("clr_one_result", 64'(nvalid), 64'(4));
    chk("clr_idx", 64'(out_idx), 64'(0));
    chk("clr_frame_cnt", 64'(frame_cnt), 64'(4));

    for (int f = 0; f < NF - 4; f++) begin
      fill_rand(1000);
      p = f % NBINS;
      re_a[p] = 20000 + int'($urandom_range(10000));
      if ($urandom_range(1) == 1) re_a[p] = -re_a[p];
      im_a[p] = int'($urandom_range(2000)) - 1000;
      if (f % 7 == 0) begin
        q = (p + 3) % NBINS;
        re_a[q] = -re_a[p];
        im_a[q] = im_a[p];
      end
      send_frame(0);
    end
    idle(1);
    wait_result(NF);
    chk("done_set", 64'(done), 64'(1));
    chk("final_frame_cnt", 64'(frame_cnt), 64'(NF));

    fill_rand(500);
    drive_beat(0, 1'b0);
    drive_beat(1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    exp_fc = 0;
    nvalid = 0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_idx", 64'(out_idx), 64'(0));
    chk("mid_rst_out_power", 64'(out_power), 64'(0));
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    idle(8);
    chk("mid_rst_no_ghost", 64'(nvalid), 64'(0));
    fill_rand(3000);
    send_frame(0);
    idle(1);
    wait_result(1);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));

`ifdef FFT_PEAK_THRESH_EN
    thresh = 33'd1000;
    th_model = 1000;
    fill(1, 1);
    re_a[5] = 20; im_a[5] = 20;
    send_frame(0);
    idle(1);
    wait_result(2);
    chk("th_nopeak", 64'(out_nopeak), 64'(1));
    chk("th_idx", 64'(out_idx), 64'(0));
    chk("th_power", 64'(out_power), 64'(800));
    idle(2);
    thresh = '0;
    th_model = 0;
`endif

    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
